servo_pwm_sched: RTL
====================

// Module: servo_pwm_sched
// PURPOSE
//  Two-channel continuous-rotation servo scheduler for the Segway drive wheels.
//  Sits between MSS fabric command registers and the servo output pins.
//  Accepts width commands via valid/ready, latches them only at frame boundaries,
//  and slew-limits each step. Staggers the two pulses within the frame.
//  Forces neutral on command timeout.
// PARAMETERS
//  FRAME_CYC      200000  frame length in SYSCLK cycles (20 ms @ 10 MHz)
//  MIN_CYC        10000   minimum pulse width (1.0 ms)
//  MAX_CYC        20000   maximum pulse width (2.0 ms)
//  NEUTRAL_CYC    15000   neutral/stop pulse width (1.5 ms)
//  CH_OFFSET      100000  ch1 pulse start offset from frame start
//  MAX_STEP       500     max change of applied width per frame
//  TIMEOUT_FRAMES 25      frames without accepted command before neutral forcing
// PORTS
//  SYSCLK        in   1   system clock, 10 MHz
//  SYSRESET      in   1   asynchronous, active-high reset
//  EN            in   1   run enable
//  CMD_VALID     in   1   command valid
//  CMD_READY     out  1   command ready
//  CMD_CH        in   1   target channel (0/1)
//  CMD_WIDTH     in   16  requested pulse width, SYSCLK cycles
//  PWM_OUT       out  2   servo pulses, bit n = channel n
//  FRAME_TICK    out  1   1-cycle pulse at each frame start
//  TIMEOUT_FLAG  out  1   watchdog expired, neutral being forced
// BEHAVIOUR
//  Reset values
//  - state IDLE, fc=0, watchdog=0.
//  - cur0/cur1/tgt0/tgt1 = NEUTRAL_CYC.
//  - PWM_OUT=0, FRAME_TICK=0, TIMEOUT_FLAG=0; CMD_READY=1 after release.
//  All outputs registered except CMD_READY, which is decoded from state/fc.
//  FSM states
//  - IDLE: PWM_OUT=0, fc held at 0, watchdog frozen. EN=1 -> RUN next cycle.
//  - RUN: fc counts 0..FRAME_CYC-1, then wraps.
//  Wrap cycle (fc==FRAME_CYC-1)
//  - CMD_READY=0.
//  - cur_n moves toward tgt_n by min(|tgt_n-cur_n|, MAX_STEP); new cur used from fc==0.
//  - watchdog increments, saturating.
//  - If EN==0: enter IDLE; otherwise stay in RUN.
//  EN deassert mid-frame: the frame completes normally, including both pulses.
//  No truncation.
//  Pulse timing
//  - PWM_OUT[0] is high for exactly cur0 cycles, rising 1 cycle after fc==0.
//  - PWM_OUT[1] is high for exactly cur1 cycles, rising 1 cycle after fc==CH_OFFSET.
//  FRAME_TICK is high in the same cycle that PWM_OUT[0] rises.
//  Commands
//  - Accepted when CMD_VALID & CMD_READY.
//  - tgt[CMD_CH] <= clamp(CMD_WIDTH, MIN_CYC, MAX_CYC).
//  - watchdog cleared, TIMEOUT_FLAG cleared.
//  - Accepted in IDLE too.
//  - A command takes effect at the next wrap; it never alters the current frame.
//  Watchdog
//  - When watchdog reaches TIMEOUT_FRAMES at a wrap, TIMEOUT_FLAG=1.
//  - Both tgt are set to NEUTRAL_CYC in that same wrap, then slew normally.
//  Back-to-back commands to one channel: last accepted value wins.
//  Async reset mid-pulse: PWM_OUT drops immediately; all state returns to reset values.
//  Arithmetic: fc 18-bit unsigned. cur/tgt 16-bit unsigned.
//  Slew difference is computed signed, 17-bit.
// TESTING
//  1. Reset, EN=1, no commands
//     -> both pulses 15000 cycles; ch1 rises 100000 cycles after ch0.
//     -> FRAME_TICK period 200000.
//  2. Cmd ch0=17000 at fc=3000
//     -> current frame stays 15000; next frames 15500, 16000, 16500, 17000, then steady.
//  3. Cmd ch1=25000 -> clamps to 20000; cmd ch1=5000 -> clamps to 10000.
//     Both reached via 500-cycle steps.
//  4. ch0 at 17000, then no commands for 25 frames
//     -> TIMEOUT_FLAG=1 at 25th wrap; width ramps to 15000 in 4 frames.
//     -> next accepted command clears the flag.
//  5. CMD_VALID held across a wrap cycle
//     -> CMD_READY=0 in that cycle; command accepted next cycle; applied one frame later.
//  6. EN low at fc=5000 -> full 15000 ch0 and ch1 pulses, then IDLE.
//     SYSRESET mid-pulse -> PWM_OUT=0 at once.

Source files
------------

// File: rtl/servo_pwm_sched.sv
`timescale 1ns/1ps
// Two-channel servo pulse scheduler.
// Commands are accepted with valid/ready and land in a target register. The
// applied widths move one bounded step toward their targets at each frame
// wrap. Channel 0 pulses at frame start and channel 1 at a fixed offset. A
// frame watchdog forces both targets to neutral when commands stop arriving.
//
// Handshake: a command transfers on any rising clock edge where CMD_VALID and
// CMD_READY are both high. CMD_READY is low only in the wrap cycle, and the
// master holds CMD_VALID/CMD_CH/CMD_WIDTH stable until the transfer happens.
module servo_pwm_sched #(
  parameter int FRAME_CYC      = 200000,
  parameter int MIN_CYC        = 10000,
  parameter int MAX_CYC        = 20000,
  parameter int NEUTRAL_CYC    = 15000,
  parameter int CH_OFFSET      = 100000,
  parameter int MAX_STEP       = 500,
  parameter int TIMEOUT_FRAMES = 25
) (
  input  logic        SYSCLK,
  input  logic        SYSRESET,
  input  logic        EN,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_CH,
  input  logic [15:0] CMD_WIDTH,
  output logic [1:0]  PWM_OUT,
  output logic        FRAME_TICK,
  output logic        TIMEOUT_FLAG
);

  localparam int WD_W = $clog2(TIMEOUT_FRAMES + 1);

  localparam logic [17:0]        FC_LAST = 18'(FRAME_CYC - 1);
  localparam logic [17:0]        FC_OFF  = 18'(CH_OFFSET);
  localparam logic [15:0]        W_MIN   = 16'(MIN_CYC);
  localparam logic [15:0]        W_MAX   = 16'(MAX_CYC);
  localparam logic [15:0]        W_NEU   = 16'(NEUTRAL_CYC);
  localparam logic [15:0]        W_STEP  = 16'(MAX_STEP);
  localparam logic signed [16:0] S_STEP  = 17'(MAX_STEP);
  localparam logic [WD_W-1:0]    WD_MAX  = WD_W'(TIMEOUT_FRAMES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [17:0]     fc_q, fc_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [WD_W-1:0] wd_inc;
  logic [15:0]     cur0_q, cur0_d, cur1_q, cur1_d;
  logic [15:0]     tgt0_q, tgt0_d, tgt1_q, tgt1_d;
  logic [1:0]      pwm_q, pwm_d;
  logic            tick_q, tick_d;
  logic            flag_q, flag_d;
  logic            wrap;
  logic            accept;

  // Limit a requested width to the legal servo range.
  function automatic logic [15:0] clamp_w(input logic [15:0] w);
    if (w < W_MIN)      clamp_w = W_MIN;
    else if (w > W_MAX) clamp_w = W_MAX;
    else                clamp_w = w;
  endfunction

  // Move cur toward tgt by at most one step; difference taken signed.
  function automatic logic [15:0] slew(input logic [15:0] cur, input logic [15:0] tgt);
    logic signed [16:0] diff;
    diff = signed'({1'b0, tgt}) - signed'({1'b0, cur});
    if (diff > S_STEP)       slew = cur + W_STEP;
    else if (diff < -S_STEP) slew = cur - W_STEP;
    else                     slew = tgt;
  endfunction

  assign wrap         = (state_q == S_RUN) && (fc_q == FC_LAST);
  assign CMD_READY    = !wrap;
  assign accept       = CMD_VALID && CMD_READY;
  assign PWM_OUT      = pwm_q;
  assign FRAME_TICK   = tick_q;
  assign TIMEOUT_FLAG = flag_q;
  assign wd_inc       = (wd_q == WD_MAX) ? WD_MAX : wd_q + WD_W'(1);

  // Next-state: frame counter, FSM, command capture, wrap-time slew/watchdog, pulse decode.
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    wd_d    = wd_q;
    flag_d  = flag_q;
    cur0_d  = cur0_q;
    cur1_d  = cur1_q;
    tgt0_d  = tgt0_q;
    tgt1_d  = tgt1_q;

    case (state_q)
      S_IDLE: begin
        fc_d = '0;
        if (EN) state_d = S_RUN;
      end
      default: begin
        if (wrap) begin
          fc_d = '0;
          if (!EN) state_d = S_IDLE;
        end else begin
          fc_d = fc_q + 18'd1;
        end
      end
    endcase

    // Never coincides with a wrap because CMD_READY is low there.
    if (accept) begin
      if (CMD_CH) tgt1_d = clamp_w(CMD_WIDTH);
      else        tgt0_d = clamp_w(CMD_WIDTH);
      wd_d   = '0;
      flag_d = 1'b0;
    end

    // The watchdog's neutral targets already steer the slew of this wrap.
    if (wrap) begin
      wd_d = wd_inc;
      if (wd_inc == WD_MAX) begin
        flag_d = 1'b1;
        tgt0_d = W_NEU;
        tgt1_d = W_NEU;
      end
      cur0_d = slew(cur0_q, tgt0_d);
      cur1_d = slew(cur1_q, tgt1_d);
    end

    pwm_d[0] = (state_q == S_RUN) && (fc_q < {2'b00, cur0_q});
    pwm_d[1] = (state_q == S_RUN) && (fc_q >= FC_OFF) &&
               (fc_q < (FC_OFF + {2'b00, cur1_q}));
    tick_d   = (state_q == S_RUN) && (fc_q == 18'd0);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      state_q <= S_IDLE;
      fc_q    <= '0;
      wd_q    <= '0;
      flag_q  <= 1'b0;
      cur0_q  <= W_NEU;
      cur1_q  <= W_NEU;
      tgt0_q  <= W_NEU;
      tgt1_q  <= W_NEU;
      pwm_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      wd_q    <= wd_d;
      flag_q  <= flag_d;
      cur0_q  <= cur0_d;
      cur1_q  <= cur1_d;
      tgt0_q  <= tgt0_d;
      tgt1_q  <= tgt1_d;
      pwm_q   <= pwm_d;
      tick_q  <= tick_d;
    end
  end

endmodule
